// File: rtl/lcd_timing_gen_pkg.sv
// Shared panel-timing defaults, stage-1 pipeline record and window-decode helper.
// The SDRAM reader imports the same defaults so frame sizing (H_ACTIVE*V_ACTIVE words) stays consistent.
package lcd_timing_gen_pkg;

    localparam int          H_ACTIVE_DEF = 800;
    localparam int          H_FP_DEF     = 210;
    localparam int          H_SYNC_DEF   = 20;
    localparam int          H_BP_DEF     = 26;
    localparam int          V_ACTIVE_DEF = 480;
    localparam int          V_FP_DEF     = 22;
    localparam int          V_SYNC_DEF   = 10;
    localparam int          V_BP_DEF     = 13;
    localparam int          CNT_W_DEF    = 11;
    localparam logic [23:0] UF_COLOR_DEF = 24'hFF00FF;

    typedef struct packed {
        logic run;
        logic active;
        logic hsync;
        logic vsync;
        logic pop;
    } stage1_t;

    function automatic logic in_window(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/lcd_timing_gen_raster.sv
// Horizontal/vertical raster counters with active, sync and frame-origin decode.
// Decodes are combinational from the counter registers; counters park at (0,0) while disabled.
module lcd_timing_gen_raster
    import lcd_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic active_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic origin_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    // Disabling always restarts from the frame origin; partial frames are abandoned.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!enable_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active_o = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    assign hsync_o  = in_window(int'(h_q), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    assign vsync_o  = in_window(int'(v_q), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    assign origin_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator and pixel-output stage; counters to pins in 2 clks, all pins registered.
// Pops one FIFO word per active pixel when available, otherwise drives UF_COLOR and flags underflow.
module lcd_timing_gen
    import lcd_timing_gen_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_DEF,
    parameter int          H_FP     = H_FP_DEF,
    parameter int          H_SYNC   = H_SYNC_DEF,
    parameter int          H_BP     = H_BP_DEF,
    parameter int          V_ACTIVE = V_ACTIVE_DEF,
    parameter int          V_FP     = V_FP_DEF,
    parameter int          V_SYNC   = V_SYNC_DEF,
    parameter int          V_BP     = V_BP_DEF,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter logic [23:0] UF_COLOR = UF_COLOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic        uf_clear,
    output logic [23:0] RGB,
    output logic        DEN,
    output logic        HSD,
    output logic        VSD,
    output logic        STBYB,
    output logic        frame_start,
    output logic        underflow
);

    logic active, hsync, vsync, origin;

    lcd_timing_gen_raster #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CNT_W    (CNT_W)
    ) u_raster (
        .clk_i    (clk),
        .reset_i  (reset),
        .enable_i (enable),
        .active_o (active),
        .hsync_o  (hsync),
        .vsync_o  (vsync),
        .origin_o (origin)
    );

    stage1_t     s1_q, s1_d;
    logic [23:0] rgb_q, rgb_d;
    logic        den_q, hsd_q, vsd_q, stbyb_q;
    logic        uf_q, uf_d;
    logic        uf_set;

    // frame_start is combinational so the first enabled clk already reports the origin.
    assign fifo_rd     = enable && !reset && active && !fifo_empty;
    assign frame_start = enable && !reset && origin;
    assign uf_set      = enable && active && fifo_empty;

    always_comb begin
        s1_d        = '0;
        s1_d.run    = enable;
        s1_d.active = enable && active;
        s1_d.hsync  = enable && hsync;
        s1_d.vsync  = enable && vsync;
        s1_d.pop    = fifo_rd;
    end

    // fifo_q is valid one clk after the pop, i.e. while the pop sits in stage 1.
    always_comb begin
        rgb_d = 24'h0;
        if (s1_q.pop) begin
            rgb_d = fifo_q;
        end else if (s1_q.active) begin
            rgb_d = UF_COLOR;
        end
    end

    always_comb begin
        uf_d = uf_q;
        if (uf_set) begin
            uf_d = 1'b1;
        end else if (uf_clear) begin
            uf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            rgb_q   <= 24'h0;
            den_q   <= 1'b0;
            hsd_q   <= 1'b1;
            vsd_q   <= 1'b1;
            stbyb_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            rgb_q   <= rgb_d;
            den_q   <= s1_q.active;
            hsd_q   <= !s1_q.hsync;
            vsd_q   <= !s1_q.vsync;
            stbyb_q <= s1_q.run;
            uf_q    <= uf_d;
        end
    end

    assign RGB       = rgb_q;
    assign DEN       = den_q;
    assign HSD       = hsd_q;
    assign VSD       = vsd_q;
    assign STBYB     = stbyb_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen with a small raster (14 x 7 clocks per frame) and a queue-based FIFO.
// The reference derives pins from the frame position and the pixel queue, delayed two clocks.
module tb_lcd_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [23:0] UFC = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        reset, enable, uf_clear, fifo_empty;
    logic [23:0] fifo_q;
    logic        fifo_rd;
    logic [23:0] RGB;
    logic        DEN, HSD, VSD, STBYB, frame_start, underflow;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CNT_W    (11), .UF_COLOR (UFC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_q      (fifo_q),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .uf_clear    (uf_clear),
        .RGB         (RGB),
        .DEN         (DEN),
        .HSD         (HSD),
        .VSD         (VSD),
        .STBYB       (STBYB),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    typedef struct packed {
        logic        den;
        logic        hs;
        logic        vs;
        logic        stby;
        logic [23:0] rgb;
    } pin_t;

    logic [23:0] drv_q[$];
    logic [23:0] ref_q[$];
    pin_t        d1, d2;
    int          pos;
    logic        m_uf;
    int          checks, errors;
    int          den_cnt, fs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] w);
        drv_q.push_back(w);
        ref_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One pixel clock: check every output mid-cycle, then advance FIFO and reference at the edge.
    task automatic tick();
        logic run, act, hs, vs, pop, fs, uf_set, rd;
        int   h, v;
        pin_t rec;
        #1;
        run    = enable && !reset;
        h      = pos % HT;
        v      = pos / HT;
        act    = run && (h < HA) && (v < VA);
        hs     = run && (h >= HA + HF) && (h < HA + HF + HS);
        vs     = run && (v >= VA + VF) && (v < VA + VF + VS);
        pop    = act && (ref_q.size() > 0);
        uf_set = act && (ref_q.size() == 0);
        fs     = run && (pos == 0);
        rec.den  = act;
        rec.hs   = hs;
        rec.vs   = vs;
        rec.stby = run;
        rec.rgb  = pop ? ref_q[0] : (act ? UFC : 24'h0);

        chk("fifo_rd", 32'(fifo_rd), 32'(pop));
        chk("frame_start", 32'(frame_start), 32'(fs));
        chk("RGB", 32'(RGB), 32'(d2.rgb));
        chk("DEN", 32'(DEN), 32'(d2.den));
        chk("HSD", 32'(HSD), 32'(!d2.hs));
        chk("VSD", 32'(VSD), 32'(!d2.vs));
        chk("STBYB", 32'(STBYB), 32'(d2.stby));
        chk("underflow", 32'(underflow), 32'(m_uf));
        if (DEN === 1'b1) den_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        rd = fifo_rd;

        @(posedge clk);
        #1;
        if (rd === 1'b1 && drv_q.size() > 0) fifo_q = drv_q.pop_front();
        fifo_empty = (drv_q.size() == 0);
        if (pop) void'(ref_q.pop_front());
        if (reset) begin
            d1   = '0;
            d2   = '0;
            m_uf = 1'b0;
            pos  = 0;
        end else begin
            d2   = d1;
            d1   = rec;
            m_uf = uf_set ? 1'b1 : (uf_clear ? 1'b0 : m_uf);
            pos  = enable ? (pos + 1) % FT : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int r;
        checks = 0; errors = 0; den_cnt = 0; fs_cnt = 0;
        reset = 1'b1; enable = 1'b0; uf_clear = 1'b0;
        fifo_empty = 1'b1; fifo_q = 24'h0;
        d1 = '0; d2 = '0; pos = 0; m_uf = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held: outputs at reset values.
        repeat (3) tick();

        // Full frame from a 32-word FIFO: pixels 0..31 in order.
        reset = 1'b0;
        for (int i = 0; i < 32; i++) push(24'(i));
        enable = 1'b1;
        den_cnt = 0; fs_cnt = 0;
        repeat (FT) tick();
        chk("t1_den_count", 32'(den_cnt), 32);
        chk("t1_fs_count", 32'(fs_cnt), 1);
        chk("t1_no_underflow", 32'(underflow), 0);

        // Only 5 words: rest of the frame in UF_COLOR, sticky set.
        for (int i = 0; i < 5; i++) push(24'($urandom));
        den_cnt = 0;
        repeat (FT) tick();
        chk("t3_den_count", 32'(den_cnt), 32);
        chk("t3_underflow_set", 32'(underflow), 1);
        enable = 1'b0;
        tick();
        uf_clear = 1'b1;
        tick();
        uf_clear = 1'b0;
        tick();
        chk("t3_uf_cleared", 32'(underflow), 0);

        // Drop enable mid-frame at h=3, v=1, then restart from the origin.
        for (int i = 0; i < 40; i++) push(24'(i + 100));
        enable = 1'b1;
        for (int k = 0; k < FT && pos != HT + 3; k++) tick();
        enable = 1'b0;
        repeat (3) tick();
        chk("t4_den_idle", 32'(DEN), 0);
        chk("t4_stbyb_idle", 32'(STBYB), 0);
        chk("t4_hsd_idle", 32'(HSD), 1);
        chk("t4_vsd_idle", 32'(VSD), 1);
        enable = 1'b1;
        #1;
        chk("t4_fs_on_enable", 32'(frame_start), 1);
        fs_cnt = 0;
        repeat (2 * FT) tick();
        chk("t5_fs_two_frames", 32'(fs_cnt), 2);

        // Reset mid-line.
        for (int k = 0; k < HT && (pos % HT) != 5; k++) tick();
        reset = 1'b1;
        tick();
        chk("t6_den_reset", 32'(DEN), 0);
        chk("t6_rgb_reset", 32'(RGB), 0);
        chk("t6_hsd_reset", 32'(HSD), 1);
        chk("t6_stbyb_reset", 32'(STBYB), 0);
        reset = 1'b0;

        // Randomized traffic: pushes, clears, occasional enable flips and resets.
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) enable = ~enable;
            if (r < 90 && drv_q.size() < 48) push(24'($urandom));
            uf_clear = (r % 17 == 0);
            reset    = (r == 100);
            tick();
        end
        reset = 1'b0; uf_clear = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
